// File: rtl/lsu_mem_if.sv
// Data-memory request/acknowledge bus between the load/store unit
// and a handshaked data memory.
interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: lane steering, extension, misalign check.
// Define LSU_TIMEOUT_EN to abort accesses that see no mem_ack in time.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    lsu_mem_if.master   mem
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cfg_err
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic        is_b, is_h, is_w, is_st, mis;
    logic [3:0]  be;
    logic [31:0] wrep;

    always_comb begin
        is_b = 1'b0;
        is_h = 1'b0;
        is_w = 1'b0;
        unique case (1'b1)
            (op == OP_LB), (op == OP_LBU), (op == OP_SB): is_b = 1'b1;
            (op == OP_LH), (op == OP_LHU), (op == OP_SH): is_h = 1'b1;
            (op == OP_LW), (op == OP_SW):                 is_w = 1'b1;
        endcase
        is_st = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
        mis   = (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));
        be    = 4'b1111;
        wrep  = wdata;
        if (is_b) begin
            be   = 4'b0001 << addr[1:0];
            wrep = {4{wdata[7:0]}};
        end else if (is_h) begin
            be   = addr[1] ? 4'b1100 : 4'b0011;
            wrep = {2{wdata[15:0]}};
        end
    end

    logic [7:0]  b_sel;
    logic [15:0] h_sel;
    logic [31:0] ld_ext;

    // Extraction uses the latched op/offset; memory data is live only with ack.
    always_comb begin
        b_sel = mem.mem_rdata[{off_q, 3'b000} +: 8];
        h_sel = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        unique case (op_q)
            OP_LB:   ld_ext = {{24{b_sel[7]}}, b_sel};
            OP_LBU:  ld_ext = {24'h0, b_sel};
            OP_LH:   ld_ext = {{16{h_sel[15]}}, h_sel};
            OP_LHU:  ld_ext = {16'h0, h_sel};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d        = op;
                    off_d       = addr[1:0];
                    mem_we_d    = is_st;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_be_d    = be;
                    mem_wdata_d = wrep;
`ifdef LSU_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                    if (mis) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = S_ACCESS;
                        mem_req_d = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                if (mem.mem_ack) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = ld_ext;
                    end
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            off_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign rdata         = rdata_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lanes, extension, misalign, reset,
// and the LSU_TIMEOUT_EN abort path when that macro is defined.
module tb_load_store_unit;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = '0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata;

    lsu_mem_if mem_bus ();

    load_store_unit #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .addr (addr),
        .wdata(wdata),
        .busy (busy),
        .done (done),
        .err  (err),
        .rdata(rdata),
        .mem  (mem_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          req_cnt, done_cyc, done_cnt;
    logic        err_at_done, we_seen;
    logic [3:0]  be_seen;
    logic [31:0] addr_seen, wd_seen;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ack_at: cycle after start (1 = first req cycle) to raise mem_ack; -1 never
    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word,
                         input int ack_at);
        req_cnt     = 0;
        done_cyc    = -1;
        done_cnt    = 0;
        err_at_done = 1'b0;
        we_seen     = 1'b0;
        be_seen     = '0;
        addr_seen   = '0;
        wd_seen     = '0;
        @(posedge clk); #1;
        start = 1'b1;
        op    = o;
        addr  = a;
        wdata = wd;
        mem_bus.mem_rdata = word;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            mem_bus.mem_ack = 1'b0;
            if (mem_bus.mem_req) begin
                req_cnt++;
                we_seen   = mem_bus.mem_we;
                be_seen   = mem_bus.mem_be;
                addr_seen = mem_bus.mem_addr;
                wd_seen   = mem_bus.mem_wdata;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc    = c;
                    err_at_done = err;
                end
            end
            if (done_cyc > 0 && c >= done_cyc + 2) break;
            if (c == ack_at) mem_bus.mem_ack = 1'b1;
        end
        mem_bus.mem_ack = 1'b0;
    endtask

    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        #12;
        check_eq("rst_ctrl", {27'h0, busy, done, err, mem_bus.mem_req,
                 mem_bus.mem_we}, 32'h0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_addr", mem_bus.mem_addr, 32'h0);
        check_eq("rst_be", {28'h0, mem_bus.mem_be}, 32'h0);
        check_eq("rst_wdata", mem_bus.mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(OP_LB, 32'h103, 32'h0, 32'h8899AABB, 3);
        check_eq("lb_req_cnt", req_cnt, 3);
        check_eq("lb_be", {28'h0, be_seen}, 32'h8);
        check_eq("lb_addr", addr_seen, 32'h100);
        check_eq("lb_we", {31'h0, we_seen}, 32'h0);
        check_eq("lb_done_cyc", done_cyc, 4);
        check_eq("lb_done_cnt", done_cnt, 1);
        check_eq("lb_err", {31'h0, err_at_done}, 32'h0);
        check_eq("lb_rdata", rdata, 32'hFFFFFF88);

        issue(OP_LBU, 32'h103, 32'h0, 32'h8899AABB, 3);
        check_eq("lbu_rdata", rdata, 32'h00000088);

        issue(OP_LH, 32'h102, 32'h0, 32'h7F001234, 1);
        check_eq("lh_hi_be", {28'h0, be_seen}, 32'hC);
        check_eq("lh_hi_rdata", rdata, 32'h00007F00);

        issue(OP_LH, 32'h100, 32'h0, 32'h00008001, 2);
        check_eq("lh_lo_be", {28'h0, be_seen}, 32'h3);
        check_eq("lh_lo_rdata", rdata, 32'hFFFF8001);

        issue(OP_LHU, 32'h100, 32'h0, 32'h00008001, 1);
        check_eq("lhu_rdata", rdata, 32'h00008001);

        issue(OP_SB, 32'h201, 32'h123456AB, 32'hDEADBEEF, 1);
        check_eq("sb_we", {31'h0, we_seen}, 32'h1);
        check_eq("sb_be", {28'h0, be_seen}, 32'h2);
        check_eq("sb_wdata", wd_seen, 32'hABABABAB);
        check_eq("sb_addr", addr_seen, 32'h200);
        check_eq("sb_done_cyc", done_cyc, 2);
        check_eq("sb_rdata_keep", rdata, 32'h00008001);

        issue(OP_SH, 32'h202, 32'h1111BEEF, 32'h0, 1);
        check_eq("sh_be", {28'h0, be_seen}, 32'hC);
        check_eq("sh_wdata", wd_seen, 32'hBEEFBEEF);

        issue(OP_LW, 32'h102, 32'h0, 32'h55555555, 1);
        check_eq("lw_mis_req", req_cnt, 0);
        check_eq("lw_mis_done_cyc", done_cyc, 1);
        check_eq("lw_mis_err", {31'h0, err_at_done}, 32'h1);
        check_eq("lw_mis_rdata", rdata, 32'h00008001);

        issue(OP_SH, 32'h005, 32'hFFFF, 32'h0, 1);
        check_eq("sh_mis_req", req_cnt, 0);
        check_eq("sh_mis_done_cyc", done_cyc, 1);
        check_eq("sh_mis_err", {31'h0, err_at_done}, 32'h1);

        @(posedge clk); #1;
        start = 1'b1;
        op    = OP_LW;
        addr  = 32'h0;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("mid_req", {31'h0, mem_bus.mem_req}, 32'h1);
        check_eq("mid_busy", {31'h0, busy}, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req", {31'h0, mem_bus.mem_req}, 32'h0);
        check_eq("mid_rst_busy", {31'h0, busy}, 32'h0);
        check_eq("mid_rst_be", {28'h0, mem_bus.mem_be}, 32'h0);
        check_eq("mid_rst_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(OP_LW, 32'h0, 32'h0, 32'hCAFEF00D, 2);
        check_eq("post_rst_done_cyc", done_cyc, 3);
        check_eq("post_rst_err", {31'h0, err_at_done}, 32'h0);
        check_eq("post_rst_rdata", rdata, 32'hCAFEF00D);

`ifdef LSU_TIMEOUT_EN
        issue(OP_LW, 32'h40, 32'h0, 32'h11223344, -1);
        check_eq("to_req_cnt", req_cnt, 4);
        check_eq("to_done_cyc", done_cyc, 5);
        check_eq("to_err", {31'h0, err_at_done}, 32'h1);
        check_eq("to_rdata_keep", rdata, 32'hCAFEF00D);

        issue(OP_LW, 32'h40, 32'h0, 32'h11223344, 4);
        check_eq("to_ack_done_cyc", done_cyc, 5);
        check_eq("to_ack_err", {31'h0, err_at_done}, 32'h0);
        check_eq("to_ack_rdata", rdata, 32'h11223344);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle data-memory access stage between the datapath and a handshaked data memory. It executes LW/LH/LHU/LB/LBU/SW/SH/SB and generates the word address, byte enables and lane-replicated store data. It extracts and sign- or zero-extends load data to 32 bits, and flags misaligned accesses. It owns the req/ack handshake so the datapath only sees start, busy and done.

Parameters:
TIMEOUT_CYCLES, 255, number of ACCESS cycles without mem_ack before abort (only with LSU_TIMEOUT_EN).
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request pulse; sampled only in IDLE.
op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
addr  input  32  byte address.
wdata  input  32  store data; low byte or halfword is used for SB or SH.
busy  output  1  high in ACCESS and DONE.
done  output  1  one-cycle completion pulse.
err  output  1  high with done on misalign or timeout.
rdata  output  32  extended load result; holds until the next successful load.
mem_req  output  1  memory request.
mem_we  output  1  1 for store ops.
mem_addr  output  32  {addr[31:2],2'b00}.
mem_be  output  4  byte enables.
mem_wdata  output  32  lane-replicated store data.
mem_rdata  input  32  read word; valid when mem_ack=1.
mem_ack  input  1  memory accept/complete.

Behaviour:
- Reset: state IDLE. All outputs are 0: busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
- Reset applies immediately in any state. A mid-access reset drops mem_req combinationally with reset and discards the transaction.
- States: IDLE, ACCESS, DONE.
- IDLE, start=1: latch op, addr and wdata.
- Misaligned start goes straight to DONE with no mem_req. Misaligned means addr[0]=1 for H/HU/SH, or addr[1:0]!=0 for W/SW. err=1 in that DONE cycle.
- Aligned start goes to ACCESS. mem_req=1 from the next cycle.
- start outside IDLE is ignored; there is no queueing.
- ACCESS: mem_req, mem_we, mem_addr, mem_be and mem_wdata stay stable until mem_ack is sampled high.
- On mem_ack in ACCESS:
  - loads capture the extracted result into rdata;
  - the next state is DONE;
  - mem_req is 0 in the next cycle.
- mem_ack is legal in the first mem_req cycle. mem_ack outside ACCESS is ignored.
- DONE: done=1 for exactly one cycle, then IDLE. start is accepted again in that IDLE cycle.
- Minimum latency: start@0, mem_req@1, ack@1, done@2. Misaligned: start@0, done/err@1.
- Byte lanes are little-endian. Byte n = bits 8n+7:8n with n=addr[1:0]. Halfword h = bits 16h+15:16h with h=addr[1].
- mem_be by op:
  - byte: one-hot (1<<addr[1:0]);
  - halfword: 0011 if addr[1]=0, 1100 if addr[1]=1;
  - word: 1111.
  - Loads drive the same pattern as stores.
- mem_wdata by op: SB = {4{wdata[7:0]}}, SH = {2{wdata[15:0]}}, SW = wdata.
- Load extension:
  - LB/LH replicate bit 7 or bit 15 of the selected lane into the upper bits;
  - LBU/LHU zero-fill;
  - LW passes the word through.
- Store completion leaves rdata unchanged. err completion leaves rdata unchanged.

Optional Feature:
LSU_TIMEOUT_EN defined:
- A CNT_W-bit counter clears on ACCESS entry and increments each ACCESS cycle without mem_ack.
- When it reaches TIMEOUT_CYCLES with mem_ack low, mem_req drops next cycle, then DONE with err=1 and rdata unchanged.
- mem_ack in the same cycle as expiry wins: normal completion, err=0.
LSU_TIMEOUT_EN undefined: no counter logic; ACCESS waits indefinitely; err reports misalignment only.

Test Plan:
1. Memory word 0x8899AABB:
   - LB addr 0x103, ack after 3 cycles -> mem_be=1000, mem_addr=0x100, done once, rdata=0xFFFFFF88, err=0.
   - LBU same -> rdata=0x00000088.
2. LH addr 0x102 on word 0x7F00_1234 -> rdata=0x00007F00.
   - LH addr 0x100 on word 0x0000_8001 -> rdata=0xFFFF8001.
   - LHU addr 0x100 on word 0x0000_8001 -> rdata=0x00008001.
3. SB addr 0x201, wdata 0x123456AB, ack same cycle as req -> mem_we=1, mem_be=0010, mem_wdata=0xABABABAB, done at start+2, rdata unchanged.
4. LW addr 0x102 -> no mem_req ever, done=err=1 at start+1.
   - SH addr 0x005 -> same misalign response.
5. Reset: assert rst_n=0 during ACCESS with mem_req=1 -> all outputs 0 immediately. After release, a new LW 0x0 with ack returns mem_rdata.
6. With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, then done=err=1.
   - Repeat with ack on cycle 4 -> err=0.
